call_ret_unit: RTL and testbench



---
 rtl/call_ret_pkg.sv | 17 +
 rtl/call_ret_depth.sv | 38 +++
 rtl/call_ret_unit.sv | 111 +++++++++++
 tb/tb_call_ret_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/call_ret_pkg.sv
// Shared types and helpers for the call/return sequencer.
// Holds the FSM state encoding and the depth-counter width function.
package call_ret_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_POP,
    ST_JUMP,
    ST_ERROR
  } state_t;

  function automatic int depth_w(input int stack_depth);
    return $clog2(stack_depth) + 1;
  endfunction

endpackage

// File: rtl/call_ret_depth.sv
// Saturating up/down counter that tracks valid return-stack entries.
// Reports full/empty so the sequencer can refuse over- and under-runs.
module call_ret_depth
  import call_ret_pkg::*;
#(
  parameter int STACK_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              i_rst_n,
  input  logic                              clk_en,
  input  logic                              inc,
  input  logic                              dec,
  output logic [depth_w(STACK_DEPTH)-1:0]   depth,
  output logic                              full,
  output logic                              empty
);

  localparam int DW = depth_w(STACK_DEPTH);

  logic [DW-1:0] depth_reg;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      depth_reg <= '0;
    end else if (clk_en) begin
      if (inc && !full) begin
        depth_reg <= depth_reg + DW'(1);
      end else if (dec && !empty) begin
        depth_reg <= depth_reg - DW'(1);
      end
    end
  end

  assign depth = depth_reg;
  assign full  = (depth_reg == DW'(STACK_DEPTH));
  assign empty = (depth_reg == '0);

endmodule

// File: rtl/call_ret_unit.sv
// Call/return sequencer: pushes return addresses, pops them back, and
// issues one-cycle PC loads. Over/underflow lock the unit until reset.
module call_ret_unit
  import call_ret_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              i_rst_n,
  input  logic                              clk_en,
  input  logic                              i_call,
  input  logic                              i_ret,
  input  logic [ADDR_W-1:0]                 i_ret_addr,
  input  logic [ADDR_W-1:0]                 i_target,
  input  logic [ADDR_W-1:0]                 i_stack_data,
  output logic                              o_push,
  output logic                              o_pop,
  output logic [ADDR_W-1:0]                 o_push_data,
  output logic                              o_pc_load,
  output logic [ADDR_W-1:0]                 o_pc_value,
  output logic                              o_busy,
  output logic [depth_w(STACK_DEPTH)-1:0]   o_depth,
  output logic                              o_overflow,
  output logic                              o_underflow
);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   push_data_reg, push_data_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic                overflow_reg, overflow_next;
  logic                underflow_reg, underflow_next;
  logic                full, empty;

  call_ret_depth #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_depth (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .clk_en  (clk_en),
    .inc     (state_reg == ST_PUSH),
    .dec     (state_reg == ST_POP),
    .depth   (o_depth),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      push_data_reg <= '0;
      pc_reg        <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clk_en) begin
      state_reg     <= state_next;
      push_data_reg <= push_data_next;
      pc_reg        <= pc_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    push_data_next = push_data_reg;
    pc_next        = pc_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    case (state_reg)
      ST_IDLE: begin
        // CALL wins when both requests arrive together
        if (i_call) begin
          if (full) begin
            state_next    = ST_ERROR;
            overflow_next = 1'b1;
          end else begin
            state_next     = ST_PUSH;
            push_data_next = i_ret_addr;
            pc_next        = i_target;
          end
        end else if (i_ret) begin
          if (empty) begin
            state_next     = ST_ERROR;
            underflow_next = 1'b1;
          end else begin
            state_next = ST_POP;
          end
        end
      end
      ST_PUSH: state_next = ST_JUMP;
      ST_POP: begin
        state_next = ST_JUMP;
        pc_next    = i_stack_data;
      end
      ST_JUMP:  state_next = ST_IDLE;
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign o_push      = (state_reg == ST_PUSH);
  assign o_pop       = (state_reg == ST_POP);
  assign o_pc_load   = (state_reg == ST_JUMP);
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_push_data = push_data_reg;
  assign o_pc_value  = pc_reg;
  assign o_overflow  = overflow_reg;
  assign o_underflow = underflow_reg;

endmodule

// File: tb/tb_call_ret_unit.sv
// Bench for call_ret_unit: directed scenarios then random CALL/RET traffic,
// checked against a queue-based return-stack model.
module tb_call_ret_unit;

  localparam int AW = 16;
  localparam int SD = 16;

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          clk_en = 1'b1;
  logic          i_call = 1'b0;
  logic          i_ret = 1'b0;
  logic [AW-1:0] i_ret_addr = '0;
  logic [AW-1:0] i_target = '0;
  logic [AW-1:0] i_stack_data;
  logic          o_push, o_pop, o_pc_load, o_busy, o_overflow, o_underflow;
  logic [AW-1:0] o_push_data, o_pc_value;
  logic [4:0]    o_depth;

  int total = 0;
  int bad = 0;

  // Reference model: the list of return addresses a correct unit holds.
  logic [AW-1:0] mstack[$];
  bit            m_err;

  // Simple attached stack memory, driven only by the DUT strobes.
  logic [AW-1:0] emu [SD];
  int            sp = 0;

  always #5 clk = ~clk;

  call_ret_unit #(.ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .clk_en(clk_en), .i_call(i_call), .i_ret(i_ret),
    .i_ret_addr(i_ret_addr), .i_target(i_target), .i_stack_data(i_stack_data),
    .o_push(o_push), .o_pop(o_pop), .o_push_data(o_push_data), .o_pc_load(o_pc_load),
    .o_pc_value(o_pc_value), .o_busy(o_busy), .o_depth(o_depth),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always @(posedge clk) begin
    if (!i_rst_n) begin
      sp <= 0;
    end else if (clk_en) begin
      if (o_push && sp < SD) begin
        emu[sp] <= o_push_data;
        sp <= sp + 1;
      end else if (o_pop && sp > 0) begin
        sp <= sp - 1;
      end
    end
  end

  assign i_stack_data = (sp > 0) ? emu[sp-1] : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("push_pop_excl", {31'd0, o_push & o_pop}, 32'd0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_call = 1'b0; i_ret = 1'b0; clk_en = 1'b1;
    tick();
    chk("rst_outs", {o_push, o_pop, o_pc_load, o_busy, o_overflow, o_underflow}, 32'd0);
    chk("rst_data", {o_push_data, o_pc_value}, 32'd0);
    chk("rst_depth", 32'(o_depth), 32'd0);
    i_rst_n = 1'b1;
    mstack.delete();
    m_err = 1'b0;
    $display("reset: outputs cleared");
  endtask

  task automatic do_call(input logic [AW-1:0] ra, input logic [AW-1:0] tg,
                         input bit with_ret, input bit glitch);
    int n;
    n = mstack.size();
    i_call = 1'b1; i_ret = with_ret; i_ret_addr = ra; i_target = tg;
    tick();
    i_call = 1'b0; i_ret = 1'b0;
    if (n < SD) begin
      chk("call_push", {31'd0, o_push}, 32'd1);
      chk("call_push_data", 32'(o_push_data), 32'(ra));
      chk("call_no_pop", {31'd0, o_pop}, 32'd0);
      chk("call_depth_pre", 32'(o_depth), 32'(n));
      if (glitch) begin
        i_call = 1'b1; i_ret = 1'b1; i_ret_addr = ~ra; i_target = ~tg;
      end
      tick();
      i_call = 1'b0; i_ret = 1'b0;
      chk("call_pc_load", {31'd0, o_pc_load}, 32'd1);
      chk("call_pc_value", 32'(o_pc_value), 32'(tg));
      chk("call_depth_post", 32'(o_depth), 32'(n + 1));
      mstack.push_back(ra);
      tick();
      chk("call_idle", {31'd0, o_busy}, 32'd0);
      $display("call ra=%h tg=%h depth=%0d", ra, tg, mstack.size());
    end else begin
      m_err = 1'b1;
      chk("ovf_flag", {31'd0, o_overflow}, 32'd1);
      repeat (2) begin
        chk("ovf_quiet", {o_busy, o_push, o_pop, o_pc_load}, 32'b1000);
        chk("ovf_depth", 32'(o_depth), 32'(SD));
        tick();
      end
      $display("call ra=%h rejected: overflow", ra);
    end
  endtask

  task automatic do_ret(input int stall);
    int n;
    logic [AW-1:0] exp_pc;
    n = mstack.size();
    i_ret = 1'b1;
    tick();
    i_ret = 1'b0;
    if (n > 0) begin
      exp_pc = mstack.pop_back();
      chk("ret_pop", {31'd0, o_pop}, 32'd1);
      chk("ret_no_push", {31'd0, o_push}, 32'd0);
      if (stall > 0) begin
        clk_en = 1'b0;
        for (int k = 0; k < stall; k++) begin
          tick();
          chk("stall_pop_held", {30'd0, o_pop, o_pc_load}, 32'b10);
          chk("stall_depth", 32'(o_depth), 32'(n));
        end
        clk_en = 1'b1;
      end
      tick();
      chk("ret_pc_load", {31'd0, o_pc_load}, 32'd1);
      chk("ret_pc_value", 32'(o_pc_value), 32'(exp_pc));
      chk("ret_depth", 32'(o_depth), 32'(n - 1));
      tick();
      chk("ret_idle", {31'd0, o_busy}, 32'd0);
      $display("ret pc=%h stall=%0d depth=%0d", exp_pc, stall, mstack.size());
    end else begin
      m_err = 1'b1;
      chk("unf_flag", {31'd0, o_underflow}, 32'd1);
      repeat (2) begin
        chk("unf_quiet", {o_busy, o_push, o_pop, o_pc_load}, 32'b1000);
        tick();
      end
      $display("ret rejected: underflow");
    end
  endtask

  initial begin
    do_reset();
    do_call(16'h0010, 16'h0200, 1'b0, 1'b0);
    do_ret(0);

    do_call(16'h0011, 16'h1000, 1'b0, 1'b0);
    do_call(16'h0022, 16'h2000, 1'b0, 1'b0);
    do_call(16'h0033, 16'h3000, 1'b0, 1'b0);
    do_ret(0);
    do_ret(0);
    do_ret(0);
    chk("nest_depth_zero", 32'(o_depth), 32'd0);

    for (int k = 0; k < SD; k++) do_call(16'h0100 + 16'(k), 16'h4000 + 16'(k), 1'b0, 1'b0);
    do_call(16'hdead, 16'hbeef, 1'b0, 1'b0);
    do_reset();

    do_ret(0);
    do_reset();

    do_call(16'h0a0a, 16'h0b0b, 1'b1, 1'b1);
    do_ret(3);
    chk("prio_underflow_clear", {31'd0, o_underflow}, 32'd0);

    i_call = 1'b1; i_ret_addr = 16'h0c0c; i_target = 16'h0d0d;
    tick();
    i_call = 1'b0;
    chk("rstpush_in_push", {31'd0, o_push}, 32'd1);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    chk("rstpush_idle", {o_busy, o_push}, 32'd0);
    chk("rstpush_depth", 32'(o_depth), 32'd0);
    mstack.delete();
    m_err = 1'b0;
    $display("reset during push: unit idle");

    for (int it = 0; it < 60; it++) begin
      if (m_err) do_reset();
      else if ($urandom_range(0, 9) < 5)
        do_call(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        do_ret(int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
